eth_rx_frame_filter: RTL and testbench
======================================

ETH_RX_FRAME_FILTER -- requirements
Module: eth_rx_frame_filter

Interface
REQ-001 net_clk  in  1  clock; all logic on rising edge.
REQ-002 sys_reset  in  1  reset, asynchronous, active-high.
REQ-003 s_axis_rx  slave axi_stream  512  frames from the RX FIFO: data[511:0], keep[63:0], last, valid, ready; byte 0 on the wire = data[7:0].
REQ-004 m_axis_rx  master axi_stream  512  filtered frames to the stack, same signal set.
REQ-005 my_mac  in  48  local MAC; my_mac[7:0] = first destination byte on the wire.
REQ-006 promisc_en  in  1  1 = pass every well-formed frame regardless of destination.
REQ-007 rx_pass_count  out  32  frames forwarded (present only with RX_FILTER_STATS_EN).
REQ-008 rx_drop_count  out  32  frames discarded (present only with RX_FILTER_STATS_EN).

Function
REQ-009 The first beat after reset, or after a beat with last=1, SHALL be the header beat; destination MAC = data[47:0].
REQ-010 Header beat SHALL be accepted (pass) if promisc_en=1, or data[47:0]==my_mac, or data[47:0]==48'hFFFF_FFFF_FFFF; otherwise rejected.
REQ-011 A header beat with last=1 and keep[13:0] != 14'h3FFF (runt, incomplete Ethernet header) SHALL be rejected regardless of REQ-010.
REQ-012 my_mac and promisc_en SHALL be sampled only on the header-beat handshake; changes mid-frame SHALL NOT affect the current frame.
REQ-013 FSM states: IDLE (expect header), PASS, DROP.
REQ-014 IDLE -> PASS on accepted header with last=0; IDLE -> DROP on rejected header with last=0; single-beat frames SHALL stay in IDLE.
REQ-015 PASS/DROP -> IDLE on the handshake of a beat with last=1; otherwise state unchanged.
REQ-016 Forwarded beats SHALL pass through one output register; latency = 1 cycle from s handshake to m_axis_rx.valid.
REQ-017 s_axis_rx.ready SHALL equal (~m_axis_rx.valid | m_axis_rx.ready) in IDLE and PASS, and 1 in DROP.
REQ-018 A rejected header beat SHALL be consumed (ready per REQ-017) but SHALL NOT load the output register.
REQ-019 Dropped beats SHALL never assert m_axis_rx.valid; data/keep/last of forwarded beats SHALL be unmodified.
REQ-020 m_axis_rx.valid, once high, SHALL hold with stable data/keep/last until m_axis_rx.ready=1.
REQ-021 Beats with s_axis_rx.valid=0 SHALL not advance the FSM; gaps inside a frame are legal.
REQ-022 Back-to-back frames (last beat followed next cycle by a header beat) SHALL be handled with no bubble.

Reset
REQ-023 On sys_reset: FSM=IDLE, m_axis_rx.valid=0, m_axis_rx.data/keep/last=0, counters=0.
REQ-024 sys_reset asserted mid-frame SHALL abandon the frame; the next beat after release SHALL be treated as a header beat.
REQ-025 sys_reset release SHALL be synchronised to net_clk (two-flop) before use.

Configuration
REQ-026 Macro RX_FILTER_STATS_EN defined: rx_pass_count increments once per forwarded frame on its header handshake, rx_drop_count once per rejected frame on its header handshake; both wrap 32'hFFFF_FFFF -> 0.
REQ-027 RX_FILTER_STATS_EN undefined: counter ports and logic SHALL be absent; filtering behaviour identical.

Verification
REQ-028 my_mac=48'h0605_0403_0201, 3-beat frame with data[47:0]=48'h0605_0403_0201, m ready=1 -> 3 beats out, each 1 cycle later, pass_count=1.
REQ-029 Same frame with data[47:0]=48'h1111_1111_1111, promisc_en=0 -> no m valid, s ready=1 all beats, drop_count=1; repeat with promisc_en=1 -> forwarded.
REQ-030 Broadcast 1-beat frame, keep=64'hFFFF_FFFF_FFFF_FFFF, last=1 -> forwarded, FSM stays IDLE; 1-beat frame keep=64'h0000_0000_0000_0FFF -> dropped.
REQ-031 Forwarded frame with m ready toggling 1,0,0,1 -> output held stable while ready=0, s ready deasserted while output full, no beat lost or duplicated.
REQ-032 sys_reset pulsed after beat 2 of a 5-beat passing frame -> m valid=0 next cycle; following matching frame forwarded intact.
REQ-033 Counter wrap (stats enabled, pass_count forced 32'hFFFF_FFFF) -> one forwarded frame yields 0.

Source files
------------

// File: rtl/eth_rx_frame_filter.sv
// ============================================================================
// Module   : eth_rx_frame_filter
// Purpose  : Destination-MAC filter between the RX FIFO and the stack on a
//            512-bit AXI-Stream. The header beat of each frame decides
//            whether the whole frame is forwarded (through a single output
//            register) or silently consumed.
// Options  : RX_FILTER_STATS_EN - adds 32-bit wrapping pass/drop frame
//            counters and their output ports.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module eth_rx_frame_filter (
  input  logic         net_clk,
  input  logic         sys_reset,
  // Frames from the RX FIFO; byte 0 on the wire is data[7:0]
  input  logic [511:0] s_axis_rx_data_i,
  input  logic [63:0]  s_axis_rx_keep_i,
  input  logic         s_axis_rx_last_i,
  input  logic         s_axis_rx_valid_i,
  output logic         s_axis_rx_ready_o,
  // Filtered frames to the stack
  output logic [511:0] m_axis_rx_data_o,
  output logic [63:0]  m_axis_rx_keep_o,
  output logic         m_axis_rx_last_o,
  output logic         m_axis_rx_valid_o,
  input  logic         m_axis_rx_ready_i,
  // Filter configuration, sampled only on the header-beat handshake
  input  logic [47:0]  my_mac_i,
  input  logic         promisc_en_i
`ifdef RX_FILTER_STATS_EN
  ,
  output logic [31:0]  rx_pass_count_o,
  output logic [31:0]  rx_drop_count_o
`endif
);

  localparam logic [47:0] BCAST_MAC    = 48'hFFFF_FFFF_FFFF;
  // An Ethernet header is 14 bytes (DA + SA + EtherType)
  localparam logic [13:0] HDR_KEEP_ALL = 14'h3FFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,   // next handshaken beat is a header beat
    ST_PASS = 2'd1,   // current frame is being forwarded
    ST_DROP = 2'd2    // current frame is being discarded
  } state_t;

  // --------------------------------------------------------------------------
  // Reset synchroniser: assertion is immediate, release is delayed two clocks
  // so every flop below leaves reset on the same edge.
  // --------------------------------------------------------------------------
  logic [1:0] rst_sync_q;
  logic       rst_int;

  // Two-flop release synchroniser for sys_reset
  always_ff @(posedge net_clk or posedge sys_reset) begin
    if (sys_reset) begin
      rst_sync_q <= 2'b11;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b0};
    end
  end

  assign rst_int = rst_sync_q[1];

  // --------------------------------------------------------------------------
  // Header decode
  // --------------------------------------------------------------------------
  logic [47:0] hdr_da;
  logic        hdr_runt;
  logic        hdr_accept;
  logic        out_free;

  assign hdr_da     = s_axis_rx_data_i[47:0];
  // A single-beat frame that does not even carry a full header is malformed
  assign hdr_runt   = s_axis_rx_last_i && (s_axis_rx_keep_i[13:0] != HDR_KEEP_ALL);
  assign hdr_accept = !hdr_runt &&
                      (promisc_en_i || (hdr_da == my_mac_i) || (hdr_da == BCAST_MAC));

  // --------------------------------------------------------------------------
  // Output register state
  // --------------------------------------------------------------------------
  logic         m_valid_q;
  logic [511:0] m_data_q;
  logic [63:0]  m_keep_q;
  logic         m_last_q;

  // The output register can take a new beat when empty or draining this cycle
  assign out_free = !m_valid_q || m_axis_rx_ready_i;

  // --------------------------------------------------------------------------
  // Frame FSM
  // --------------------------------------------------------------------------
  state_t state_q;
  state_t state_d;
  logic   rx_ready;
  logic   rx_hs;
  logic   load_out;

  // State register
  always_ff @(posedge net_clk or posedge rst_int) begin
    if (rst_int) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, input ready and output-register load enable
  always_comb begin
    rx_ready = 1'b0;
    rx_hs    = 1'b0;
    load_out = 1'b0;
    state_d  = state_q;

    // Dropped beats never touch the output register, so DROP sinks freely
    case (state_q)
      ST_IDLE: rx_ready = out_free;
      ST_PASS: rx_ready = out_free;
      ST_DROP: rx_ready = 1'b1;
      default: rx_ready = 1'b0;
    endcase

    // Nothing is consumed while the synchronised reset is still held
    if (rst_int) begin
      rx_ready = 1'b0;
    end

    rx_hs = s_axis_rx_valid_i && rx_ready;

    case (state_q)
      ST_IDLE: begin
        if (rx_hs) begin
          load_out = hdr_accept;
          // Single-beat frames complete here and leave the FSM in IDLE
          if (!s_axis_rx_last_i) begin
            state_d = hdr_accept ? ST_PASS : ST_DROP;
          end
        end
      end
      ST_PASS: begin
        if (rx_hs) begin
          load_out = 1'b1;
          if (s_axis_rx_last_i) begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DROP: begin
        if (rx_hs && s_axis_rx_last_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign s_axis_rx_ready_o = rx_ready;

  // --------------------------------------------------------------------------
  // Output register
  // --------------------------------------------------------------------------

  // Valid flag: set on load, cleared once the stack takes the beat
  always_ff @(posedge net_clk or posedge rst_int) begin
    if (rst_int) begin
      m_valid_q <= 1'b0;
    end else if (load_out) begin
      m_valid_q <= 1'b1;
    end else if (m_axis_rx_ready_i) begin
      m_valid_q <= 1'b0;
    end
  end

  // Payload: loaded only with forwarded beats, otherwise held stable
  always_ff @(posedge net_clk or posedge rst_int) begin
    if (rst_int) begin
      m_data_q <= '0;
      m_keep_q <= '0;
      m_last_q <= 1'b0;
    end else if (load_out) begin
      m_data_q <= s_axis_rx_data_i;
      m_keep_q <= s_axis_rx_keep_i;
      m_last_q <= s_axis_rx_last_i;
    end
  end

  assign m_axis_rx_valid_o = m_valid_q;
  assign m_axis_rx_data_o  = m_data_q;
  assign m_axis_rx_keep_o  = m_keep_q;
  assign m_axis_rx_last_o  = m_last_q;

  // --------------------------------------------------------------------------
  // Optional frame statistics
  // --------------------------------------------------------------------------
`ifdef RX_FILTER_STATS_EN
  logic [31:0] pass_cnt_q;
  logic [31:0] drop_cnt_q;
  logic        hdr_hs;

  // Each frame is counted exactly once, on its header handshake
  assign hdr_hs = rx_hs && (state_q == ST_IDLE);

  // Pass/drop counters, wrapping naturally at 2^32
  always_ff @(posedge net_clk or posedge rst_int) begin
    if (rst_int) begin
      pass_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else if (hdr_hs) begin
      if (hdr_accept) begin
        pass_cnt_q <= pass_cnt_q + 32'd1;
      end else begin
        drop_cnt_q <= drop_cnt_q + 32'd1;
      end
    end
  end

  assign rx_pass_count_o = pass_cnt_q;
  assign rx_drop_count_o = drop_cnt_q;
`endif

  // --------------------------------------------------------------------------
  // Protocol properties
  // --------------------------------------------------------------------------

  // A stalled output beat must not change underneath the stack
  a_out_stable: assert property (
    @(posedge net_clk) disable iff (rst_int)
    (m_valid_q && !m_axis_rx_ready_i) |=>
      (m_valid_q && $stable(m_data_q) && $stable(m_keep_q) && $stable(m_last_q))
  );

  // Discarded frames never reach the output register
  a_drop_no_load: assert property (
    @(posedge net_clk) disable iff (rst_int)
    (state_q == ST_DROP) |-> !load_out
  );

endmodule

`default_nettype wire

// File: tb/tb_eth_rx_frame_filter.sv
// ============================================================================
// Module   : tb_eth_rx_frame_filter
// Purpose  : Directed, table-driven bench for eth_rx_frame_filter. Each
//            vector drives one cycle of inputs and states the s-side ready
//            and the m-side output expected in that same cycle. Reset and
//            counter corner cases run as short hand-written sequences.
//            Counter checks are built when RX_FILTER_STATS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_eth_rx_frame_filter;

  localparam logic [47:0] MAC  = 48'h0605_0403_0201;
  localparam logic [47:0] OTH  = 48'h1111_1111_1111;
  localparam logic [47:0] OTH2 = 48'h2222_2222_2222;
  localparam logic [47:0] BC   = 48'hFFFF_FFFF_FFFF;
  localparam logic [63:0] FK   = 64'hFFFF_FFFF_FFFF_FFFF;

  logic         net_clk = 1'b0;
  logic         sys_reset;
  logic [511:0] s_data;
  logic [63:0]  s_keep;
  logic         s_last;
  logic         s_valid;
  logic         s_ready;
  logic [511:0] m_data;
  logic [63:0]  m_keep;
  logic         m_last;
  logic         m_valid;
  logic         m_ready;
  logic [47:0]  my_mac;
  logic         promisc;
`ifdef RX_FILTER_STATS_EN
  logic [31:0]  pass_cnt;
  logic [31:0]  drop_cnt;
`endif

  always #5 net_clk = ~net_clk;

  eth_rx_frame_filter dut (
    .net_clk           (net_clk),
    .sys_reset         (sys_reset),
    .s_axis_rx_data_i  (s_data),
    .s_axis_rx_keep_i  (s_keep),
    .s_axis_rx_last_i  (s_last),
    .s_axis_rx_valid_i (s_valid),
    .s_axis_rx_ready_o (s_ready),
    .m_axis_rx_data_o  (m_data),
    .m_axis_rx_keep_o  (m_keep),
    .m_axis_rx_last_o  (m_last),
    .m_axis_rx_valid_o (m_valid),
    .m_axis_rx_ready_i (m_ready),
    .my_mac_i          (my_mac),
    .promisc_en_i      (promisc)
`ifdef RX_FILTER_STATS_EN
    ,
    .rx_pass_count_o   (pass_cnt),
    .rx_drop_count_o   (drop_cnt)
`endif
  );

  typedef struct {
    logic        sv;     // s valid
    logic [47:0] da;     // data[47:0]
    logic [7:0]  tag;    // fills data[511:48]
    logic [63:0] keep;
    logic        sl;     // s last
    logic        mr;     // m ready
    logic        pr;     // promisc
    logic [47:0] mac;
    logic        esr;    // expected s ready
    logic        emv;    // expected m valid
    logic [7:0]  etag;   // expected output beat tag
    logic [47:0] eda;    // expected output data[47:0]
    logic [63:0] ekeep;
    logic        el;     // expected m last
  } vec_t;

  vec_t vecs [32];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic logic [511:0] mk(input logic [7:0] t, input logic [47:0] da);
    return {{58{t}}, da};
  endfunction

  function automatic logic [47:0] bd(input logic [7:0] t);
    return {6{t}};
  endfunction

  function automatic vec_t mkv(input logic sv, input logic [47:0] da, input logic [7:0] tag,
                               input logic [63:0] keep, input logic sl, input logic mr,
                               input logic pr, input logic [47:0] mac, input logic esr,
                               input logic emv, input logic [7:0] etag, input logic [47:0] eda,
                               input logic [63:0] ekeep, input logic el);
    vec_t v;
    v.sv = sv; v.da = da; v.tag = tag; v.keep = keep; v.sl = sl; v.mr = mr;
    v.pr = pr; v.mac = mac; v.esr = esr; v.emv = emv; v.etag = etag; v.eda = eda;
    v.ekeep = ekeep; v.el = el;
    return v;
  endfunction

  // Shorthand for an idle input cycle
  function automatic vec_t idle(input logic mr, input logic esr, input logic emv,
                                input logic [7:0] etag, input logic [47:0] eda,
                                input logic [63:0] ekeep, input logic el);
    return mkv(1'b0, 48'h0, 8'h00, 64'h0, 1'b0, mr, 1'b0, MAC, esr, emv, etag, eda, ekeep, el);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    s_valid = v.sv;
    s_data  = mk(v.tag, v.da);
    s_keep  = v.keep;
    s_last  = v.sl;
    m_ready = v.mr;
    promisc = v.pr;
    my_mac  = v.mac;
    @(negedge net_clk);
    chk($sformatf("v%0d s_ready", idx), 64'(s_ready), 64'(v.esr));
    chk($sformatf("v%0d m_valid", idx), 64'(m_valid), 64'(v.emv));
    if (v.emv) begin
      n_chk++;
      if (m_data !== mk(v.etag, v.eda)) begin
        n_fail++;
        $display("FAIL v%0d m_data: got tag %0h da %0h, expected tag %0h da %0h",
                 idx, m_data[511:504], m_data[47:0], v.etag, v.eda);
      end
      chk($sformatf("v%0d m_keep", idx), m_keep, v.ekeep);
      chk($sformatf("v%0d m_last", idx), 64'(m_last), 64'(v.el));
    end
    @(posedge net_clk);
    #1;
  endtask

  // Hard stop in case the run ever stalls
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    sys_reset = 1'b1;
    s_valid   = 1'b0;
    s_data    = '0;
    s_keep    = '0;
    s_last    = 1'b0;
    m_ready   = 1'b1;
    my_mac    = MAC;
    promisc   = 1'b0;

    // sel: sv  da        tag    keep          sl mr pr mac  | esr emv etag  eda       ekeep         el
    vecs[0]  = mkv(1, MAC,      8'hA1, FK,           0, 1, 0, MAC,  1, 0, 8'h00, 48'h0,    64'h0,        0);
    vecs[1]  = mkv(1, bd(8'hA2), 8'hA2, FK,          0, 1, 0, MAC,  1, 1, 8'hA1, MAC,      FK,           0);
    vecs[2]  = mkv(1, bd(8'hA3), 8'hA3, FK,          1, 1, 0, MAC,  1, 1, 8'hA2, bd(8'hA2), FK,          0);
    vecs[3]  = idle(1,                                              1, 1, 8'hA3, bd(8'hA3), FK,          1);
    vecs[4]  = mkv(1, OTH,      8'hB1, FK,           0, 1, 0, MAC,  1, 0, 8'h00, 48'h0,    64'h0,        0);
    vecs[5]  = mkv(1, bd(8'hB2), 8'hB2, FK,          0, 0, 0, MAC,  1, 0, 8'h00, 48'h0,    64'h0,        0);
    vecs[6]  = mkv(1, bd(8'hB3), 8'hB3, FK,          1, 0, 0, MAC,  1, 0, 8'h00, 48'h0,    64'h0,        0);
    vecs[7]  = mkv(1, OTH,      8'hC1, FK,           0, 1, 1, MAC,  1, 0, 8'h00, 48'h0,    64'h0,        0);
    vecs[8]  = mkv(1, bd(8'hC2), 8'hC2, FK,          0, 1, 0, MAC,  1, 1, 8'hC1, OTH,      FK,           0);
    vecs[9]  = mkv(1, bd(8'hC3), 8'hC3, FK,          1, 1, 0, MAC,  1, 1, 8'hC2, bd(8'hC2), FK,          0);
    vecs[10] = mkv(1, BC,       8'hD1, FK,           1, 1, 0, MAC,  1, 1, 8'hC3, bd(8'hC3), FK,          1);
    vecs[11] = mkv(1, MAC,      8'hE1, 64'h0FFF,     1, 1, 0, MAC,  1, 1, 8'hD1, BC,       FK,           1);
    vecs[12] = mkv(1, MAC,      8'hF1, FK,           0, 1, 0, MAC,  1, 0, 8'h00, 48'h0,    64'h0,        0);
    vecs[13] = mkv(0, 48'h0,    8'h00, 64'h0,        0, 1, 0, 48'h0, 1, 1, 8'hF1, MAC,     FK,           0);
    vecs[14] = mkv(1, bd(8'hF2), 8'hF2, FK,          1, 1, 0, 48'h0, 1, 0, 8'h00, 48'h0,   64'h0,        0);
    vecs[15] = idle(1,                                              1, 1, 8'hF2, bd(8'hF2), FK,          1);
    vecs[16] = mkv(1, MAC,      8'h71, 64'h3FFF,     1, 1, 0, MAC,  1, 0, 8'h00, 48'h0,    64'h0,        0);
    vecs[17] = idle(1,                                              1, 1, 8'h71, MAC,      64'h3FFF,     1);
    vecs[18] = idle(1,                                              1, 0, 8'h00, 48'h0,    64'h0,        0);
    vecs[19] = mkv(1, MAC,      8'h81, FK,           0, 1, 0, MAC,  1, 0, 8'h00, 48'h0,    64'h0,        0);
    vecs[20] = mkv(1, bd(8'h82), 8'h82, FK,          0, 0, 0, MAC,  0, 1, 8'h81, MAC,      FK,           0);
    vecs[21] = mkv(1, bd(8'h82), 8'h82, FK,          0, 0, 0, MAC,  0, 1, 8'h81, MAC,      FK,           0);
    vecs[22] = mkv(1, bd(8'h82), 8'h82, FK,          0, 1, 0, MAC,  1, 1, 8'h81, MAC,      FK,           0);
    vecs[23] = mkv(1, bd(8'h83), 8'h83, FK,          1, 1, 0, MAC,  1, 1, 8'h82, bd(8'h82), FK,          0);
    vecs[24] = idle(1,                                              1, 1, 8'h83, bd(8'h83), FK,          1);
    vecs[25] = idle(1,                                              1, 0, 8'h00, 48'h0,    64'h0,        0);
    vecs[26] = mkv(1, MAC,      8'h91, FK,           1, 1, 0, MAC,  1, 0, 8'h00, 48'h0,    64'h0,        0);
    vecs[27] = mkv(1, OTH2,     8'h95, FK,           0, 0, 0, MAC,  0, 1, 8'h91, MAC,      FK,           1);
    vecs[28] = mkv(1, OTH2,     8'h95, FK,           0, 1, 0, MAC,  1, 1, 8'h91, MAC,      FK,           1);
    vecs[29] = mkv(1, bd(8'h96), 8'h96, FK,          0, 0, 0, MAC,  1, 0, 8'h00, 48'h0,    64'h0,        0);
    vecs[30] = mkv(1, bd(8'h97), 8'h97, FK,          1, 0, 0, MAC,  1, 0, 8'h00, 48'h0,    64'h0,        0);
    vecs[31] = idle(1,                                              1, 0, 8'h00, 48'h0,    64'h0,        0);

    // Power-on reset, then check the reset state while release is synchronised
    repeat (3) @(posedge net_clk);
    #1;
    sys_reset = 1'b0;
    @(negedge net_clk);
    chk("reset s_ready", 64'(s_ready), 64'h0);
    chk("reset m_valid", 64'(m_valid), 64'h0);
    chk("reset m_data", m_data[63:0], 64'h0);
    chk("reset m_keep", m_keep, 64'h0);
    chk("reset m_last", 64'(m_last), 64'h0);
`ifdef RX_FILTER_STATS_EN
    chk("reset pass_cnt", 64'(pass_cnt), 64'h0);
    chk("reset drop_cnt", 64'(drop_cnt), 64'h0);
`endif
    repeat (2) @(posedge net_clk);
    #1;

    for (int i = 0; i < 32; i++) begin
      run_vec(vecs[i], i);
    end

`ifdef RX_FILTER_STATS_EN
    // Passed: A C D F G H J; dropped: B E K
    chk("table pass_cnt", 64'(pass_cnt), 64'd7);
    chk("table drop_cnt", 64'(drop_cnt), 64'd3);
`endif

    // Reset in the middle of a 5-beat passing frame
    run_vec(mkv(1, MAC, 8'h31, FK, 0, 1, 0, MAC, 1, 0, 8'h00, 48'h0, 64'h0, 0), 100);
    run_vec(mkv(1, bd(8'h32), 8'h32, FK, 0, 1, 0, MAC, 1, 1, 8'h31, MAC, FK, 0), 101);
    sys_reset = 1'b1;
    s_valid   = 1'b0;
    #1;
    chk("midrst m_valid", 64'(m_valid), 64'h0);
    chk("midrst m_data", m_data[63:0], 64'h0);
`ifdef RX_FILTER_STATS_EN
    chk("midrst pass_cnt", 64'(pass_cnt), 64'h0);
`endif
    repeat (2) @(posedge net_clk);
    #1;
    sys_reset = 1'b0;
    @(negedge net_clk);
    chk("midrst s_ready held", 64'(s_ready), 64'h0);
    repeat (2) @(posedge net_clk);
    #1;
    // First beat after release is a header: non-matching, so dropped
    run_vec(mkv(1, OTH, 8'h51, FK, 1, 1, 0, MAC, 1, 0, 8'h00, 48'h0, 64'h0, 0), 102);
    run_vec(mkv(1, MAC, 8'h41, FK, 0, 1, 0, MAC, 1, 0, 8'h00, 48'h0, 64'h0, 0), 103);
    run_vec(mkv(1, bd(8'h42), 8'h42, FK, 0, 1, 0, MAC, 1, 1, 8'h41, MAC, FK, 0), 104);
    run_vec(mkv(1, bd(8'h43), 8'h43, FK, 1, 1, 0, MAC, 1, 1, 8'h42, bd(8'h42), FK, 0), 105);
    run_vec(idle(1, 1, 1, 8'h43, bd(8'h43), FK, 1), 106);
    run_vec(idle(1, 1, 0, 8'h00, 48'h0, 64'h0, 0), 107);

`ifdef RX_FILTER_STATS_EN
    chk("post-rst pass_cnt", 64'(pass_cnt), 64'd1);
    chk("post-rst drop_cnt", 64'(drop_cnt), 64'd1);

    // Pass counter wrap
    force dut.pass_cnt_q = 32'hFFFF_FFFF;
    @(posedge net_clk);
    #1;
    release dut.pass_cnt_q;
    chk("wrap preset", 64'(pass_cnt), 64'hFFFF_FFFF);
    run_vec(mkv(1, MAC, 8'h61, FK, 1, 1, 0, MAC, 1, 0, 8'h00, 48'h0, 64'h0, 0), 200);
    chk("wrap pass_cnt", 64'(pass_cnt), 64'h0);
    run_vec(idle(1, 1, 1, 8'h61, MAC, FK, 1), 201);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
